// File: rtl/uart_tx_eight_ten.sv
// uart_tx_eight_ten: UART transmitter that frames one byte per request.
//   sel=0 -> 10-bit frame: start, 8 data bits LSB first, stop.
//   sel=1 -> 11-bit frame: start, 8 data bits LSB first, even parity, stop.
// Each bit is held for 'baud' clock cycles (0 behaves as 1).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   sel          frame format select, latched at accept
//   baud         clock cycles per bit, latched at accept
//   tx_en        enable; dropping it aborts a frame in progress
//   tx_start     send request, only honoured while idle
//   tx_data      byte to send, latched at accept
//   tx_out       serial line (idle high), registered
//   tx_busy      high while a frame is on the line
//   tx_done      one-cycle pulse after a frame completes normally
//   bit_cnt_out  index of the bit currently driven, 0 when idle
//   frame_o      latched frame, bit 0 is the first bit on the line
module uart_tx_eight_ten #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [BAUD_W-1:0] baud,
    input  logic              tx_en,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [3:0]        bit_cnt_out,
    output logic [10:0]       frame_o
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [10:0]       frame_q, frame_d;
    logic              sel_q, sel_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;

    logic [3:0]        next_idx;
    logic [3:0]        last_idx;

    assign next_idx = bit_cnt_q + 4'd1;
    assign last_idx = sel_q ? 4'd10 : 4'd9;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        sel_d     = sel_q;
        baud_d    = baud_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
                cnt_d     = '0;
                if (tx_en && tx_start) begin
                    // Bit 9 is parity in 8E1; in 8N1 it is the stop bit and bit 10 is an idle pad.
                    frame_d = {1'b1, (sel ? ^tx_data : 1'b1), tx_data, 1'b0};
                    sel_d   = sel;
                    baud_d  = (baud == '0) ? BAUD_W'(1) : baud;
                    state_d = StSend;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StSend: begin
                if (!tx_en) begin
                    state_d   = StIdle;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                end else if (cnt_q == baud_q - BAUD_W'(1)) begin
                    cnt_d = '0;
                    if (bit_cnt_q == last_idx) begin
                        state_d   = StIdle;
                        tx_d      = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = next_idx;
                        tx_d      = frame_q[next_idx];
                    end
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 11'd0;
            sel_q     <= 1'b0;
            baud_q    <= BAUD_W'(1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            sel_q     <= sel_d;
            baud_q    <= baud_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tx_out      = tx_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign bit_cnt_out = bit_cnt_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_uart_tx_eight_ten.sv
// Self-checking bench for uart_tx_eight_ten: table of directed frames plus
// hand-written back-to-back, abort, ignore/latch and mid-frame reset sequences.
module tb_uart_tx_eight_ten;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [19:0] baud;
    logic        tx_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;
    logic [3:0]  bit_cnt_out;
    logic [10:0] frame_o;

    int errors = 0;
    int checks = 0;

    uart_tx_eight_ten dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .baud        (baud),
        .tx_en       (tx_en),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .bit_cnt_out (bit_cnt_out),
        .frame_o     (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [19:0] baud;
        logic [7:0]  data;
        logic [10:0] frame;   // hand-computed expected frame
        int          beff;    // effective cycles per bit
        int          flen;    // frame length in bits
        int          done_at; // cycles after accept at which tx_done pulses
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one vector; optionally disturbs inputs mid-frame to prove they are ignored.
    task automatic run_vec(input vec_t v, input bit perturb);
        logic [10:0] f;
        int          idx;
        f        = v.frame;
        sel      = v.sel;
        baud     = v.baud;
        tx_data  = v.data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 1; k <= v.done_at; k++) begin
            if (perturb && k == 10) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
                baud     = 20'd9;
                sel      = 1'b1;
            end
            if (perturb && k == 11) tx_start = 1'b0;
            if (k < v.done_at) begin
                idx = (k - 1) / v.beff;
                chk("line_bit", {31'd0, tx_out}, {31'd0, f[idx]});
                chk("busy", {31'd0, tx_busy}, 32'd1);
                chk("done_low", {31'd0, tx_done}, 32'd0);
                chk("bit_cnt", {28'd0, bit_cnt_out}, idx);
            end else begin
                chk("done_pulse", {31'd0, tx_done}, 32'd1);
                chk("done_idle_line", {31'd0, tx_out}, 32'd1);
                chk("done_busy", {31'd0, tx_busy}, 32'd0);
                chk("done_bit_cnt", {28'd0, bit_cnt_out}, 32'd0);
                chk("frame_o", {21'd0, frame_o}, {21'd0, f});
            end
            tick();
        end
        chk("done_one_cycle", {31'd0, tx_done}, 32'd0);
        chk("frame_hold", {21'd0, frame_o}, {21'd0, f});
    endtask

    initial begin
        int first;
        int second;
        int ndone;
        int nbusy;

        vecs[0] = '{1'b0, 20'd4, 8'hA5, 11'h74A, 4, 10, 41};
        vecs[1] = '{1'b1, 20'd3, 8'h07, 11'h60E, 3, 11, 34};
        vecs[2] = '{1'b1, 20'd2, 8'h55, 11'h4AA, 2, 11, 23};
        vecs[3] = '{1'b0, 20'd0, 8'h00, 11'h600, 1, 10, 11};
        vecs[4] = '{1'b0, 20'd1, 8'hA5, 11'h74A, 1, 10, 11};
        vecs[5] = '{1'b1, 20'd1, 8'hFF, 11'h5FE, 1, 11, 12};

        rst      = 1'b0;
        sel      = 1'b0;
        baud     = 20'd4;
        tx_en    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #22;
        chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_bit_cnt", {28'd0, bit_cnt_out}, 32'd0);
        chk("rst_frame", {21'd0, frame_o}, 32'd0);
        rst = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 1'b0);
            tick();
        end

        // Back-to-back with tx_start held: one idle cycle between frames.
        sel      = 1'b0;
        baud     = 20'd2;
        tx_data  = 8'h55;
        tx_start = 1'b1;
        first    = 0;
        second   = 0;
        tick();
        for (int c = 1; c <= 60; c++) begin
            if (c == 22) tx_start = 1'b0;
            if (first != 0 && c == first + 1) begin
                chk("b2b_start_bit", {31'd0, tx_out}, 32'd0);
                chk("b2b_busy", {31'd0, tx_busy}, 32'd1);
            end
            if (tx_done) begin
                if (first == 0) begin
                    first = c;
                    chk("b2b_gap_high", {31'd0, tx_out}, 32'd1);
                    tx_data = 8'hAA;
                end else if (second == 0) begin
                    second = c;
                end else begin
                    chk("b2b_extra_done", 32'd1, 32'd0);
                end
            end
            tick();
        end
        chk("b2b_first_done", first, 32'd21);
        chk("b2b_second_done", second, 32'd42);
        chk("b2b_frame", {21'd0, frame_o}, 32'h754);

        // Abort at data bit 3 (line index 4).
        sel      = 1'b0;
        baud     = 20'd8;
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int c = 1; c < 35; c++) tick();
        chk("abort_pre_bit_cnt", {28'd0, bit_cnt_out}, 32'd4);
        tx_en = 1'b0;
        tick();
        chk("abort_tx_out", {31'd0, tx_out}, 32'd1);
        chk("abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("abort_bit_cnt", {28'd0, bit_cnt_out}, 32'd0);
        // Start while disabled must be ignored.
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_done) ndone++;
            if (tx_busy) nbusy++;
            tick();
        end
        tx_en = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (tx_done) ndone++;
            if (tx_busy) nbusy++;
            tick();
        end
        chk("abort_no_done", ndone, 32'd0);
        chk("abort_no_busy", nbusy, 32'd0);

        // Mid-frame start/data/baud/sel changes are ignored and not queued.
        run_vec('{1'b0, 20'd4, 8'h3C, 11'h678, 4, 10, 41}, 1'b1);
        nbusy = 0;
        for (int c = 0; c < 50; c++) begin
            if (tx_busy) nbusy++;
            tick();
        end
        chk("ignore_no_second_frame", nbusy, 32'd0);

        // Async reset in the middle of the stop bit.
        sel      = 1'b0;
        baud     = 20'd4;
        tx_data  = 8'h81;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int c = 1; c < 38; c++) tick();
        chk("rst_mid_pre_bit_cnt", {28'd0, bit_cnt_out}, 32'd9);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_tx_out", {31'd0, tx_out}, 32'd1);
        chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_mid_done", {31'd0, tx_done}, 32'd0);
        chk("rst_mid_bit_cnt", {28'd0, bit_cnt_out}, 32'd0);
        chk("rst_mid_frame", {21'd0, frame_o}, 32'd0);
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (tx_done) ndone++;
            tick();
        end
        chk("rst_mid_no_done", ndone, 32'd0);
        run_vec(vecs[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_eight_ten.md
Name: uart_tx_eight_ten

Overview:
UART transmitter that frames an 8-bit byte into a 10-bit frame (start, 8 data LSB-first, stop) or, with parity selected, an 11-bit frame (start, 8 data, even parity, stop). Bit timing comes from a programmable per-bit clock count. It is the transmit counterpart of the 10-to-8 receive path in the UART combine block and shares its baud/frame conventions. It is driven by a simple start/busy/done handshake.

Parameters:
DATA_W, 8, payload width (fixed at 8; parity and frame sizing assume 8)
BAUD_W, 20, width of baud divisor and internal baud counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sel  input  1  0 = 8N1 (10-bit frame); 1 = 8E1 (11-bit frame, even parity)
baud  input  BAUD_W  clk cycles per bit; 0 is treated as 1
tx_en  input  1  transmitter enable; low aborts any frame in progress
tx_start  input  1  request to send tx_data; sampled in IDLE only
tx_data  input  8  byte to transmit
tx_out  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse at normal frame completion
bit_cnt_out  output  4  index of bit currently driven, 0..frame_len-1; 0 in IDLE
frame_o  output  11  latched frame, bit 0 = start bit (first on line)

Behaviour:
- Reset (rst=0, async): state IDLE, tx_out=1, tx_busy=0, tx_done=0, bit_cnt_out=0, frame_o=0, baud counter=0.
- States: IDLE, SEND. Bit type is derived from bit_cnt_out: 0 start, 1..8 data, 9 parity or stop, 10 stop (sel=1 only).
- Accept: in cycle N with state IDLE, tx_en=1 and tx_start=1, latch tx_data, sel, and baud (0 becomes 1).
  - Build frame_o as {1, p, tx_data, 0} for sel=1, with p = XOR of tx_data (even parity).
  - Build frame_o as {1, 1, tx_data, 0} for sel=0, where bit 10 is an idle pad.
  - Go to SEND; bit_cnt_out=0.
- Latency: tx_out=frame_o[0]=0 and tx_busy=1 from cycle N+1.
- Each bit is held exactly baud_latched cycles. The baud counter counts 0..baud_latched-1. At wrap it resets to 0 and bit_cnt_out increments.
- tx_out = frame_o[bit_cnt_out] during SEND. frame_len = 10 (sel latched 0) or 11 (sel latched 1).
- Completion: the last bit occupies cycles up to N+frame_len*baud_latched. In cycle N+1+frame_len*baud_latched:
  - state = IDLE, tx_out=1, tx_busy=0, tx_done=1 (one cycle), bit_cnt_out=0.
  - frame_o holds its last value until the next accept.
- Back-to-back: tx_start is accepted in the tx_done cycle. tx_out stays 1 for exactly that one cycle, then the next start bit begins.
- tx_start while busy: ignored and not queued. tx_data, sel and baud changes mid-frame have no effect.
- tx_en=0 during SEND (abort): next cycle state IDLE, tx_out=1, tx_busy=0, bit_cnt_out=0, baud counter=0, and no tx_done.
- tx_en=0 in IDLE: tx_start is ignored.
- Reset mid-frame: immediate return to reset values with no tx_done. The first accept after release behaves normally.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- 8N1, baud=4, tx_data=0xA5, start at N -> tx_out sequence, each bit held 4 cycles from N+1: 0,1,0,1,0,0,1,0,1,1. tx_done pulses at N+41; frame_o=0x74A (bits 9:0 = 0x34A).
- 8E1, baud=3, tx_data=0x07 -> parity bit=1. Line: 0,1,1,1,0,0,0,0,0,1,1, each bit 3 cycles. tx_done at N+34.
- Back-to-back: 0x55 then 0xAA, baud=2, tx_start held high -> exactly one idle-high cycle between the frames. Two tx_done pulses 21 cycles apart.
- Abort: 8N1, baud=8, drop tx_en at data bit 3 -> tx_out=1 and tx_busy=0 the next cycle. No tx_done; bit_cnt_out=0.
- Ignore and latch checks: tx_start pulsed with different tx_data, and baud changed from 4 to 9, mid-frame -> frame unchanged, bit timing unchanged, no second frame.
- Edge cases: baud=0 and baud=1 -> 1 cycle per bit, tx_done at N+11 for 8N1. Async reset asserted mid-stop-bit -> outputs at reset values immediately (tx_out=1, tx_busy=0, tx_done=0, bit_cnt_out=0, frame_o=0).
